partial_sum_accum: RTL and testbench

PARTIAL_SUM_ACCUM -- requirements
Module: partial_sum_accum

---
 rtl/partial_sum_pkg.sv | 50 +++++
 rtl/psum_bank.sv | 62 ++++++
 rtl/partial_sum_accum.sv | 176 +++++++++++++++++
 tb/tb_partial_sum_accum.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/partial_sum_pkg.sv
// Shared definitions for the partial-sum accumulator: pipeline depth,
// per-stage operation record, forwarding select and saturation helper.
package partial_sum_pkg;

  // Cycles from read address to read data at the bank output mux.
  localparam int RD_LATENCY = 3;

  // Widest address the control pipeline carries; narrower addresses
  // are zero-extended so forwarding compares stay exact.
  localparam int PSUM_MAX_ADDR_WIDTH = 16;

  // One operation as it travels down the shared control pipeline.
  typedef struct packed {
    logic                           valid;
    logic [PSUM_MAX_ADDR_WIDTH-1:0] addr;
    logic                           first;
    logic                           last;
  } pipe_op_t;

  // Source of the accumulate operand in the add stage.
  // H0 is the youngest writeback, H2 the oldest one not yet seen by the RAM read.
  typedef enum logic [2:0] {
    FWD_RAM,
    FWD_ZERO,
    FWD_H0,
    FWD_H1,
    FWD_H2
  } fwd_sel_e;

  typedef enum logic [1:0] {
    SAT_NONE,
    SAT_POS,
    SAT_NEG
  } sat_e;

  // Overflow of a two's-complement add happens only when both operands
  // share a sign and the sum's sign differs; width-independent.
  function automatic sat_e sat_check(input logic sat_en,
                                     input logic a_msb,
                                     input logic b_msb,
                                     input logic sum_msb);
    sat_e kind;
    kind = SAT_NONE;
    if (sat_en && (a_msb == b_msb) && (sum_msb != a_msb)) begin
      kind = a_msb ? SAT_NEG : SAT_POS;
    end
    return kind;
  endfunction

endpackage

// File: rtl/psum_bank.sv
// One channel's partial-sum storage: several simple-dual-port block RAMs
// selected by the upper address bits, each with a 3-cycle registered read.
module psum_bank
  import partial_sum_pkg::*;
#(
  parameter int ADDR_WIDTH      = 10,
  parameter int BANK_ADDR_WIDTH = 9,
  parameter int ACC_WIDTH       = 64
) (
  input  logic                                  clk,
  input  logic                                  rd_en,
  input  logic [ADDR_WIDTH-1:0]                 rd_addr,
  input  logic [ADDR_WIDTH-BANK_ADDR_WIDTH-1:0] rd_bank_sel,
  output logic [ACC_WIDTH-1:0]                  rd_data,
  input  logic                                  wr_en,
  input  logic [ADDR_WIDTH-1:0]                 wr_addr,
  input  logic [ACC_WIDTH-1:0]                  wr_data
);

  localparam int BANK_BITS  = ADDR_WIDTH - BANK_ADDR_WIDTH;
  localparam int NUM_BANKS  = 1 << BANK_BITS;
  localparam int BANK_DEPTH = 1 << BANK_ADDR_WIDTH;

  logic [ACC_WIDTH-1:0] bank_q [NUM_BANKS];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
      logic [ACC_WIDTH-1:0] mem [BANK_DEPTH];
      logic [ACC_WIDTH-1:0] q_reg [RD_LATENCY];
      logic                 rd_hit;
      logic                 wr_hit;

      // Only the addressed bank sees its ports enabled.
      assign rd_hit = rd_en && (rd_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH] == BANK_BITS'(gi));
      assign wr_hit = wr_en && (wr_addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH] == BANK_BITS'(gi));

      // Write port: stores the add-stage result.
      always_ff @(posedge clk) begin
        if (wr_hit) begin
          mem[wr_addr[BANK_ADDR_WIDTH-1:0]] <= wr_data;
        end
      end

      // Read port: array read register followed by output pipeline registers.
      always_ff @(posedge clk) begin
        if (rd_hit) begin
          q_reg[0] <= mem[rd_addr[BANK_ADDR_WIDTH-1:0]];
        end
        for (int s = 1; s < RD_LATENCY; s++) begin
          q_reg[s] <= q_reg[s-1];
        end
      end

      assign bank_q[gi] = q_reg[RD_LATENCY-1];
    end
  endgenerate

  // Select is the bank bits of the operation now leaving the read pipeline.
  assign rd_data = bank_q[rd_bank_sel];

endmodule

// File: rtl/partial_sum_accum.sv
// Multi-channel partial-sum accumulator. A single shared control pipeline
// tracks each operation through the RAM read latency and resolves
// read-after-write hazards by address compare against the last three
// writebacks; each channel only replicates its data path and RAM.
module partial_sum_accum
  import partial_sum_pkg::*;
#(
  parameter int NUM_CH          = 64,
  parameter int DATA_WIDTH      = 48,
  parameter int ACC_WIDTH       = 64,
  parameter int ADDR_WIDTH      = 10,
  parameter int BANK_ADDR_WIDTH = 9,
  parameter int SAT_MODE        = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic [DATA_WIDTH-1:0] in_data [NUM_CH],
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [ACC_WIDTH-1:0]  out_data [NUM_CH]
);

  localparam int BANK_BITS = ADDR_WIDTH - BANK_ADDR_WIDTH;

  pipe_op_t                       op_next;
  pipe_op_t                       stage_reg [RD_LATENCY];
  pipe_op_t                       cur_op;
  logic                           hist_valid_reg [RD_LATENCY];
  logic [PSUM_MAX_ADDR_WIDTH-1:0] hist_addr_reg  [RD_LATENCY];
  fwd_sel_e                       fwd_sel;
  logic                           ram_rd_en;
  logic                           ram_wr_en;
  logic [BANK_BITS-1:0]           rd_bank_sel;
  logic [ADDR_WIDTH-1:0]          cur_addr;
  logic                           out_fire;
  logic                           out_valid_reg;
  logic [ADDR_WIDTH-1:0]          out_addr_reg;

  // Package the incoming operation; control fields are don't-care without in_valid.
  always_comb begin
    op_next = '0;
    if (in_valid) begin
      op_next.valid = 1'b1;
      op_next.addr  = PSUM_MAX_ADDR_WIDTH'(in_addr);
      op_next.first = in_first;
      op_next.last  = in_last;
    end
  end

  assign cur_op      = stage_reg[RD_LATENCY-1];
  assign cur_addr    = cur_op.addr[ADDR_WIDTH-1:0];
  assign rd_bank_sel = cur_op.addr[ADDR_WIDTH-1:BANK_ADDR_WIDTH];
  assign ram_rd_en   = in_valid && !rst;
  assign ram_wr_en   = cur_op.valid && !rst;
  assign out_fire    = cur_op.valid && cur_op.last;

  // Control pipeline, writeback history and output control; reset flushes everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        stage_reg[s]      <= '0;
        hist_valid_reg[s] <= 1'b0;
        hist_addr_reg[s]  <= '0;
      end
      out_valid_reg <= 1'b0;
      out_addr_reg  <= '0;
    end else begin
      stage_reg[0]      <= op_next;
      hist_valid_reg[0] <= cur_op.valid;
      hist_addr_reg[0]  <= cur_op.addr;
      for (int s = 1; s < RD_LATENCY; s++) begin
        stage_reg[s]      <= stage_reg[s-1];
        hist_valid_reg[s] <= hist_valid_reg[s-1];
        hist_addr_reg[s]  <= hist_addr_reg[s-1];
      end
      out_valid_reg <= out_fire;
      if (out_fire) begin
        out_addr_reg <= cur_addr;
      end
    end
  end

  // Pick the newest copy of the operand: zero for overwrite, else youngest matching writeback, else RAM.
  always_comb begin
    fwd_sel = FWD_RAM;
    if (cur_op.first) begin
      fwd_sel = FWD_ZERO;
    end else if (hist_valid_reg[0] && (hist_addr_reg[0] == cur_op.addr)) begin
      fwd_sel = FWD_H0;
    end else if (hist_valid_reg[1] && (hist_addr_reg[1] == cur_op.addr)) begin
      fwd_sel = FWD_H1;
    end else if (hist_valid_reg[2] && (hist_addr_reg[2] == cur_op.addr)) begin
      fwd_sel = FWD_H2;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_addr  = out_addr_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [DATA_WIDTH-1:0] data_pipe_reg [RD_LATENCY];
      logic [ACC_WIDTH-1:0]  hist_data_reg [RD_LATENCY];
      logic [ACC_WIDTH-1:0]  ram_rd_data;
      logic [ACC_WIDTH-1:0]  base_val;
      logic [ACC_WIDTH-1:0]  addend;
      logic [ACC_WIDTH-1:0]  raw_sum;
      logic [ACC_WIDTH-1:0]  new_val;
      logic [ACC_WIDTH-1:0]  out_data_reg;
      sat_e                  sat_kind;

      psum_bank #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .BANK_ADDR_WIDTH (BANK_ADDR_WIDTH),
        .ACC_WIDTH       (ACC_WIDTH)
      ) u_bank (
        .clk         (clk),
        .rd_en       (ram_rd_en),
        .rd_addr     (in_addr),
        .rd_bank_sel (rd_bank_sel),
        .rd_data     (ram_rd_data),
        .wr_en       (ram_wr_en),
        .wr_addr     (cur_addr),
        .wr_data     (new_val)
      );

      // Sample travels alongside its control record; writebacks are kept for forwarding.
      always_ff @(posedge clk) begin
        data_pipe_reg[0] <= in_data[gi];
        hist_data_reg[0] <= new_val;
        for (int s = 1; s < RD_LATENCY; s++) begin
          data_pipe_reg[s] <= data_pipe_reg[s-1];
          hist_data_reg[s] <= hist_data_reg[s-1];
        end
      end

      // Add stage: operand select, sign-extended add, optional clamp.
      always_comb begin
        addend   = ACC_WIDTH'($signed(data_pipe_reg[RD_LATENCY-1]));
        base_val = ram_rd_data;
        case (fwd_sel)
          FWD_ZERO: base_val = '0;
          FWD_H0:   base_val = hist_data_reg[0];
          FWD_H1:   base_val = hist_data_reg[1];
          FWD_H2:   base_val = hist_data_reg[2];
          default:  base_val = ram_rd_data;
        endcase
        raw_sum  = base_val + addend;
        sat_kind = sat_check(SAT_MODE != 0, base_val[ACC_WIDTH-1],
                             addend[ACC_WIDTH-1], raw_sum[ACC_WIDTH-1]);
        case (sat_kind)
          SAT_POS: new_val = {1'b0, {(ACC_WIDTH-1){1'b1}}};
          SAT_NEG: new_val = {1'b1, {(ACC_WIDTH-1){1'b0}}};
          default: new_val = raw_sum;
        endcase
      end

      // Result register holds its value until the next emitted result.
      always_ff @(posedge clk) begin
        if (rst) begin
          out_data_reg <= '0;
        end else if (out_fire) begin
          out_data_reg <= new_val;
        end
      end

      assign out_data[gi] = out_data_reg;
    end
  endgenerate

endmodule

// File: tb/tb_partial_sum_accum.sv
// Directed and random checks of partial_sum_accum: one wrap instance with
// 48-bit samples, plus 64-bit-sample wrap and saturate instances.
module tb_partial_sum_accum;

  localparam int NCH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_first;
  logic        in_last;
  logic [9:0]  in_addr;
  logic [47:0] d48 [NCH];
  logic [63:0] d64 [NCH];
  logic        ov    [3];
  logic [9:0]  oaddr [3];
  logic [63:0] od0 [NCH];
  logic [63:0] od1 [NCH];
  logic [63:0] od2 [NCH];

  partial_sum_accum #(.NUM_CH(NCH), .DATA_WIDTH(48), .ACC_WIDTH(64), .ADDR_WIDTH(10),
                      .BANK_ADDR_WIDTH(9), .SAT_MODE(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_first(in_first),
    .in_last(in_last), .in_data(d48), .out_valid(ov[0]), .out_addr(oaddr[0]), .out_data(od0));

  partial_sum_accum #(.NUM_CH(NCH), .DATA_WIDTH(64), .ACC_WIDTH(64), .ADDR_WIDTH(10),
                      .BANK_ADDR_WIDTH(9), .SAT_MODE(0)) dut_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_first(in_first),
    .in_last(in_last), .in_data(d64), .out_valid(ov[1]), .out_addr(oaddr[1]), .out_data(od1));

  partial_sum_accum #(.NUM_CH(NCH), .DATA_WIDTH(64), .ACC_WIDTH(64), .ADDR_WIDTH(10),
                      .BANK_ADDR_WIDTH(9), .SAT_MODE(1)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_addr(in_addr), .in_first(in_first),
    .in_last(in_last), .in_data(d64), .out_valid(ov[2]), .out_addr(oaddr[2]), .out_data(od2));

  always #5 clk = ~clk;

  int          errors   = 0;
  int          checks   = 0;
  int          edge_n   = 0;
  bit          mon_en   = 1'b0;
  logic [63:0] val [NCH];
  logic [63:0] mdl [3][NCH][1024];
  bit          known [1024];
  bit          exp_v [8];
  logic [9:0]  exp_a [8];
  logic [63:0] exp_d [8][3][NCH];

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic logic [63:0] get_od(input int i, input int ch);
    case (i)
      0:       return od0[ch];
      1:       return od1[ch];
      default: return od2[ch];
    endcase
  endfunction

  // Reference arithmetic done 65 bits wide, clamped when the result leaves the 64-bit range.
  function automatic logic [63:0] model_add(input bit sat, input logic [63:0] a, input logic [63:0] b);
    logic [64:0] w;
    w = {a[63], a} + {b[63], b};
    if (sat && (w[64] != w[63])) return w[64] ? 64'h8000_0000_0000_0000 : 64'h7FFF_FFFF_FFFF_FFFF;
    return w[63:0];
  endfunction

  task automatic set_all(input logic [63:0] v);
    for (int ch = 0; ch < NCH; ch++) val[ch] = v;
  endtask

  // Issue one operation using val[], update the sequential model, schedule the expected output.
  task automatic op(input logic [9:0] a, input bit f, input bit l);
    int slot;
    logic [63:0] opnd, base, res;
    slot = (edge_n + 4) % 8;
    in_valid = 1'b1; in_addr = a; in_first = f; in_last = l;
    for (int ch = 0; ch < NCH; ch++) begin
      d48[ch] = val[ch][47:0];
      d64[ch] = val[ch];
      for (int i = 0; i < 3; i++) begin
        opnd = (i == 0) ? {{16{val[ch][47]}}, val[ch][47:0]} : val[ch];
        base = f ? 64'd0 : mdl[i][ch][a];
        res  = model_add(i == 2, base, opnd);
        mdl[i][ch][a] = res;
        exp_d[slot][i][ch] = res;
      end
    end
    known[a] = 1'b1;
    if (l) begin
      exp_v[slot] = 1'b1;
      exp_a[slot] = a;
    end
    $display("op edge=%0d addr=%h first=%0b last=%0b data0=%h", edge_n + 1, a, f, l, val[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Idle cycle; control and data inputs carry junk that must be ignored.
  task automatic idle();
    in_valid = 1'b0;
    in_first = 1'($urandom);
    in_last  = 1'b1;
    in_addr  = 10'($urandom);
    for (int ch = 0; ch < NCH; ch++) begin
      d48[ch] = 48'($urandom);
      d64[ch] = {$urandom, $urandom};
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    for (int k = 1; k <= 4; k++) exp_v[(edge_n + k) % 8] = 1'b0;
    rst = 1'b1; in_valid = 1'b1; in_first = 1'b1; in_last = 1'b1; in_addr = 10'($urandom);
    repeat (n) begin @(posedge clk); #1; end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst out_valid i%0d", i), 64'(ov[i]), 64'd0);
      check($sformatf("rst out_addr i%0d", i), 64'(oaddr[i]), 64'd0);
      check($sformatf("rst out_data i%0d", i), get_od(i, 0), 64'd0);
    end
    rst = 1'b0; in_valid = 1'b0;
    for (int a = 0; a < 1024; a++) known[a] = 1'b0;
    mon_en = 1'b1;
    $display("reset done edge=%0d", edge_n);
  endtask

  // Hand-computed check of an emitted result on one instance, all channels.
  task automatic hand(input string tag, input int i, input logic [9:0] a, input logic [63:0] v);
    check({tag, " valid"}, 64'(ov[i]), 64'd1);
    check({tag, " addr"}, 64'(oaddr[i]), 64'(a));
    for (int ch = 0; ch < NCH; ch++) check($sformatf("%s data ch%0d", tag, ch), get_od(i, ch), v);
  endtask

  // Scoreboard: every cycle, out_valid must match the schedule; emitted results must match the model.
  always @(negedge clk) begin
    if (mon_en) begin
      int slot;
      slot = edge_n % 8;
      for (int i = 0; i < 3; i++) begin
        check($sformatf("out_valid i%0d", i), 64'(ov[i]), 64'(exp_v[slot]));
        if (exp_v[slot]) begin
          check($sformatf("out_addr i%0d", i), 64'(oaddr[i]), 64'(exp_a[slot]));
          for (int ch = 0; ch < NCH; ch++)
            check($sformatf("out_data i%0d ch%0d", i, ch), get_od(i, ch), exp_d[slot][i][ch]);
        end
      end
      exp_v[slot] = 1'b0;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int s = 0; s < 8; s++) exp_v[s] = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; in_addr = '0;
    for (int ch = 0; ch < NCH; ch++) begin d48[ch] = '0; d64[ch] = '0; end
    #1;
    do_reset(2);

    // Back-to-back accumulation on one address: 10+1+2+3 = 16.
    set_all(64'd10); op(10'd5, 1, 0);
    set_all(64'd1);  op(10'd5, 0, 0);
    set_all(64'd2);  op(10'd5, 0, 0);
    set_all(64'd3);  op(10'd5, 0, 1);
    repeat (3) idle();
    hand("b2b", 0, 10'd5, 64'd16);

    // Alternating banks, 8 increments each.
    set_all(64'd1);
    for (int k = 0; k < 16; k++) op(k[0] ? 10'h200 : 10'h000, k < 2, k >= 14);
    repeat (2) idle();
    hand("bank0", 0, 10'h000, 64'd8);
    idle();
    hand("bank1", 0, 10'h200, 64'd8);

    // Same address at gaps of 1..4 idle cycles: 1+2+3+4+5 = 15.
    set_all(64'd1); op(10'd9, 1, 0);
    for (int g = 1; g <= 4; g++) begin
      repeat (g) idle();
      set_all(64'(g + 1)); op(10'd9, 0, g == 4);
    end
    repeat (3) idle();
    hand("gaps", 0, 10'd9, 64'd15);

    // Positive overflow: saturate instance clamps, wrap instance goes negative.
    set_all(64'h7FFF_FFFF_FFFF_FFFF); op(10'd7, 1, 1);
    set_all(64'd1);
    repeat (3) op(10'd7, 0, 1);
    repeat (3) idle();
    hand("sat_pos", 2, 10'd7, 64'h7FFF_FFFF_FFFF_FFFF);
    hand("wrap_pos", 1, 10'd7, 64'h8000_0000_0000_0002);
    hand("w48_pos", 0, 10'd7, 64'd2);

    // Negative overflow.
    set_all(64'h8000_0000_0000_0000); op(10'd8, 1, 0);
    set_all(64'hFFFF_FFFF_FFFF_FFFF); op(10'd8, 0, 1);
    repeat (3) idle();
    hand("sat_neg", 2, 10'd8, 64'h8000_0000_0000_0000);
    hand("wrap_neg", 1, 10'd8, 64'h7FFF_FFFF_FFFF_FFFF);

    // Reset one cycle after an in_last issue discards it; fresh ops work right after.
    set_all(64'd5); op(10'd3, 1, 1);
    do_reset(1);
    set_all(64'd9); op(10'd3, 1, 1);
    set_all(64'd4); op(10'd3, 0, 1);
    repeat (3) idle();
    hand("post_rst", 0, 10'd3, 64'd13);
    hand("post_rst_sat", 2, 10'd3, 64'd13);

    // first+last together at the top address, negative sample sign-extended; output then holds.
    set_all(64'hFFFF_FFFF_FFFF_FFF9); op(10'd1023, 1, 1);
    repeat (3) idle();
    hand("neg7", 0, 10'd1023, 64'hFFFF_FFFF_FFFF_FFF9);
    repeat (2) idle();
    check("hold valid", 64'(ov[0]), 64'd0);
    check("hold addr", 64'(oaddr[0]), 64'd1023);
    check("hold data", od0[NCH-1], 64'hFFFF_FFFF_FFFF_FFF9);

    // Random traffic concentrated on a few addresses across both banks.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        idle();
      end else begin
        logic [9:0] a;
        if ($urandom_range(0, 7) == 0) a = 10'($urandom);
        else a = ($urandom_range(0, 1) != 0 ? 10'h200 : 10'h000) | 10'($urandom_range(0, 3));
        for (int ch = 0; ch < NCH; ch++) val[ch] = {$urandom, $urandom};
        op(a, !known[a] || ($urandom_range(0, 15) == 0), $urandom_range(0, 3) == 0);
      end
    end
    repeat (6) idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
